postnorm_round_mvp: RTL

Pipelined post-normalisation, rounding and packing stage for the multi-precision div/sqrt unit. It sits directly downstream of the non-restoring div/sqrt core. It accepts the pre-normalised mantissa/exponent when the core signals done, normalises it (including subnormal right-shift), rounds per RISC-V mode and packs an IEEE result with NaN-boxing. A two-register pipeline with valid/ready backpressure decouples the iterative core from the consumer.

---
 rtl/defs_div_sqrt_mvp.sv | 79 +++++++
 rtl/round_pack_mvp.sv | 66 ++++++
 rtl/postnorm_round_mvp.sv | 112 +++++++++++
 3 files changed

// File: rtl/defs_div_sqrt_mvp.sv
// Shared definitions for the multi-precision div/sqrt unit: rounding modes,
// format selects, per-format exponent/fraction parameters and flag indices.
package defs_div_sqrt_mvp;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    typedef enum logic [1:0] {
        FMT_FP32    = 2'b00,
        FMT_FP64    = 2'b01,
        FMT_FP16    = 2'b10,
        FMT_FP16ALT = 2'b11
    } fmt_e;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;

    localparam logic [12:0] BIAS_FP64    = 13'd1023;
    localparam logic [12:0] BIAS_FP32    = 13'd127;
    localparam logic [12:0] BIAS_FP16    = 13'd15;
    localparam logic [12:0] BIAS_FP16ALT = 13'd127;

    localparam logic [12:0] MAXEXP_FP64    = 13'd2047;
    localparam logic [12:0] MAXEXP_FP32    = 13'd255;
    localparam logic [12:0] MAXEXP_FP16    = 13'd31;
    localparam logic [12:0] MAXEXP_FP16ALT = 13'd255;

    localparam logic [5:0] FRAC_FP64    = 6'd52;
    localparam logic [5:0] FRAC_FP32    = 6'd23;
    localparam logic [5:0] FRAC_FP16    = 6'd10;
    localparam logic [5:0] FRAC_FP16ALT = 6'd7;

    // Normalised operand handed from stage 1 to stage 2; frac is right-aligned.
    typedef struct packed {
        logic        sign;
        logic [12:0] exp;
        logic        hidden;
        logic [51:0] frac;
        logic        guard;
        logic        sticky;
        fmt_e        fmt;
        rm_e         rm;
        logic        tiny;
    } s1_t;

    function automatic logic [5:0] frac_width(fmt_e f);
        case (f)
            FMT_FP64: frac_width = FRAC_FP64;
            FMT_FP32: frac_width = FRAC_FP32;
            FMT_FP16: frac_width = FRAC_FP16;
            default:  frac_width = FRAC_FP16ALT;
        endcase
    endfunction

    function automatic logic [12:0] max_exp(fmt_e f);
        case (f)
            FMT_FP64: max_exp = MAXEXP_FP64;
            FMT_FP32: max_exp = MAXEXP_FP32;
            FMT_FP16: max_exp = MAXEXP_FP16;
            default:  max_exp = MAXEXP_FP16ALT;
        endcase
    endfunction

    function automatic logic [12:0] fmt_bias(fmt_e f);
        case (f)
            FMT_FP64: fmt_bias = BIAS_FP64;
            FMT_FP32: fmt_bias = BIAS_FP32;
            FMT_FP16: fmt_bias = BIAS_FP16;
            default:  fmt_bias = BIAS_FP16ALT;
        endcase
    endfunction

endpackage

// File: rtl/round_pack_mvp.sv
// Combinational rounding, overflow handling and IEEE packing with NaN-boxing
// of narrow formats.
module round_pack_mvp
    import defs_div_sqrt_mvp::*;
(
    input  s1_t         s1,
    output logic [63:0] result,
    output logic [2:0]  flags
);

    logic [5:0]  fw;
    logic [12:0] mx;
    logic        up, carry, nh, of, inf, nx, uf;
    logic [53:0] full, rnd;
    logic [12:0] exp_r;
    logic [10:0] exp_o;
    logic [51:0] frac_o;

    always_comb begin
        fw = frac_width(s1.fmt);
        mx = max_exp(s1.fmt);

        case (s1.rm)
            RM_RNE:  up = s1.guard & (s1.sticky | s1.frac[0]);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = s1.sign & (s1.guard | s1.sticky);
            RM_RUP:  up = !s1.sign & (s1.guard | s1.sticky);
            RM_RMM:  up = s1.guard;
            default: up = 1'b0;
        endcase

        // Hidden bit sits at position fw, so carry-out lands at fw+1.
        full  = ({53'b0, s1.hidden} << fw) | {2'b0, s1.frac};
        rnd   = full + {53'b0, up};
        carry = rnd[fw + 6'd1];
        nh    = rnd[fw];

        exp_r = s1.tiny ? {12'b0, nh} : s1.exp + {12'b0, carry};
        of    = (s1.exp >= mx) | (exp_r >= mx);
        inf   = (s1.rm == RM_RNE) | (s1.rm == RM_RMM) |
                ((s1.rm == RM_RUP) & !s1.sign) | ((s1.rm == RM_RDN) & s1.sign);

        exp_o  = exp_r[10:0];
        frac_o = rnd[51:0];
        if (of) begin
            exp_o  = inf ? mx[10:0] : mx[10:0] - 11'd1;
            frac_o = inf ? '0 : '1;
        end

        nx = s1.guard | s1.sticky | of;
        uf = (exp_r == '0) & nx;

        flags          = '0;
        flags[FLAG_OF] = of;
        flags[FLAG_UF] = uf;
        flags[FLAG_NX] = nx;

        case (s1.fmt)
            FMT_FP64: result = {s1.sign, exp_o, frac_o};
            FMT_FP32: result = {32'hFFFF_FFFF, s1.sign, exp_o[7:0], frac_o[22:0]};
            FMT_FP16: result = {48'hFFFF_FFFF_FFFF, s1.sign, exp_o[4:0], frac_o[9:0]};
            default:  result = {48'hFFFF_FFFF_FFFF, s1.sign, exp_o[7:0], frac_o[6:0]};
        endcase
    end

endmodule

// File: rtl/postnorm_round_mvp.sv
// Post-normalisation / rounding / packing stage behind the div/sqrt core:
// normalise + subnormal shift into s1, then round/pack into output registers.
module postnorm_round_mvp
    import defs_div_sqrt_mvp::*;
(
    input  logic        Clk_CI,
    input  logic        Rst_RBI,
    input  logic        Kill_SI,
    input  logic        Valid_SI,
    output logic        Ready_SO,
    input  logic [56:0] Mant_in_DI,
    input  logic [12:0] Exp_in_DI,
    input  logic        Sign_in_DI,
    input  logic [1:0]  Format_sel_SI,
    input  logic [2:0]  RM_SI,
    output logic        Valid_SO,
    input  logic        Out_ready_SI,
    output logic [63:0] Result_DO,
    output logic [2:0]  Flags_SO
);

    logic               out_adv, accept, s1_valid;
    s1_t                s1_q, s1_d;
    logic [63:0]        rp_result;
    logic [2:0]         rp_flags;

    logic [56:0]        m_n, mm;
    logic signed [13:0] e_n;
    logic [13:0]        amt;
    logic [5:0]         sh;
    logic [113:0]       wide;
    logic               tiny, sh_st;

    assign out_adv  = !Valid_SO | Out_ready_SI;
    assign Ready_SO = !s1_valid | out_adv;
    assign accept   = Valid_SI & Ready_SO;

    always_comb begin
        m_n  = Mant_in_DI[56] ? Mant_in_DI : {Mant_in_DI[55:0], 1'b0};
        e_n  = {Exp_in_DI[12], Exp_in_DI} - {13'b0, ~Mant_in_DI[56]};
        tiny = (e_n <= 14'sd0);
        amt  = 14'd1 - e_n;
        sh   = tiny ? ((amt > 14'd58) ? 6'd58 : amt[5:0]) : 6'd0;
        // Bits shifted out of the 57-bit window fold into sticky.
        wide  = {m_n, 57'b0} >> sh;
        mm    = wide[113:57];
        sh_st = |wide[56:0];

        s1_d        = '0;
        s1_d.sign   = Sign_in_DI;
        s1_d.exp    = tiny ? '0 : e_n[12:0];
        s1_d.hidden = mm[56];
        s1_d.fmt    = fmt_e'(Format_sel_SI);
        s1_d.rm     = rm_e'(RM_SI);
        s1_d.tiny   = tiny;
        case (fmt_e'(Format_sel_SI))
            FMT_FP64: begin
                s1_d.frac   = mm[55:4];
                s1_d.guard  = mm[3];
                s1_d.sticky = |mm[2:0] | sh_st;
            end
            FMT_FP32: begin
                s1_d.frac   = {29'b0, mm[55:33]};
                s1_d.guard  = mm[32];
                s1_d.sticky = |mm[31:0] | sh_st;
            end
            FMT_FP16: begin
                s1_d.frac   = {42'b0, mm[55:46]};
                s1_d.guard  = mm[45];
                s1_d.sticky = |mm[44:0] | sh_st;
            end
            default: begin
                s1_d.frac   = {45'b0, mm[55:49]};
                s1_d.guard  = mm[48];
                s1_d.sticky = |mm[47:0] | sh_st;
            end
        endcase
    end

    round_pack_mvp u_round_pack (
        .s1     (s1_q),
        .result (rp_result),
        .flags  (rp_flags)
    );

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            Valid_SO  <= 1'b0;
            Result_DO <= '0;
            Flags_SO  <= '0;
        end else begin
            if (Kill_SI)
                s1_valid <= 1'b0;
            else if (Ready_SO)
                s1_valid <= Valid_SI;
            if (accept && !Kill_SI)
                s1_q <= s1_d;

            if (Kill_SI)
                Valid_SO <= 1'b0;
            else if (out_adv)
                Valid_SO <= s1_valid;
            if (out_adv && s1_valid && !Kill_SI) begin
                Result_DO <= rp_result;
                Flags_SO  <= rp_flags;
            end
        end
    end

endmodule
